apb_arbiter: RTL
================

Name: apb_arbiter

Overview:
- Round-robin arbiter that shares one APB slave port (the matrix-multiplier register/memory window) between NUM_MASTERS APB masters, e.g. the host CPU bridge and the DMA/test loader.
- Each master sees a normal APB slave with extra wait states.
- The arbiter runs its own SETUP/ACCESS sequence on the slave side and returns pready only to the granted master.

Parameters:
- NUM_MASTERS, 2, number of requesting APB masters (2..8).
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width.

Ports:
- pclk  input  1  single clock, all logic on rising edge.
- preset_n  input  1  reset, synchronous, active-low.
- m_paddr  input  NUM_MASTERS*ADDR_WIDTH  master addresses, master i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_psel  input  NUM_MASTERS  per-master psel.
- m_penable  input  NUM_MASTERS  per-master penable.
- m_pwrite  input  NUM_MASTERS  per-master pwrite.
- m_pwdata  input  NUM_MASTERS*DATA_WIDTH  per-master write data.
- m_pready  output  NUM_MASTERS  per-master pready.
- m_prdata  output  DATA_WIDTH  read data, broadcast to all masters.
- s_paddr  output  ADDR_WIDTH  slave address.
- s_psel  output  1  slave psel.
- s_penable  output  1  slave penable.
- s_pwrite  output  1  slave pwrite.
- s_pwdata  output  DATA_WIDTH  slave write data.
- s_pready  input  1  slave pready.
- s_prdata  input  DATA_WIDTH  slave read data.
- grant  output  NUM_MASTERS  one-hot current owner, 0 when idle.

Behaviour:
- FSM states and registers:
  - States IDLE, SETUP, ACCESS; state is registered.
  - Registered: grant index g, priority pointer ptr.
- Reset (preset_n=0 at a clock edge): state=IDLE, g=0, ptr=0. Outputs after that edge: s_psel=0, s_penable=0, m_pready=0, grant=0.
  - Reset in SETUP or ACCESS aborts the slave transfer; no m_pready pulse is issued.
- IDLE:
  - req = m_psel. If req==0, stay IDLE.
  - Otherwise pick the first set bit scanning ptr, ptr+1, …, wrapping mod NUM_MASTERS. Register it as g and go to SETUP.
  - Requests in either phase (penable 0 or 1) are eligible.
- SETUP: s_psel=1, s_penable=0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - s_psel=1, s_penable=1.
  - Wait while s_pready=0.
  - When s_pready=1: go to IDLE next cycle and set ptr=(g+1) mod NUM_MASTERS.
- Slave-side muxing:
  - s_paddr, s_pwrite, s_pwdata = slices of master g while state is SETUP or ACCESS; all 0 in IDLE.
  - These are combinational muxes. Masters hold their signals stable per APB, so the slave sees stable values throughout the transfer.
- m_pready[i] = (state==ACCESS) & (g==i) & s_pready & m_penable[i]. This is combinational, in the same cycle as s_pready. All other bits are 0.
- m_prdata = s_prdata, all cycles. Masters sample it only with their own pready.
- grant = one-hot(g) in SETUP/ACCESS, else 0.
- Latency: with a zero-wait slave, master setup at cycle 0 → arbiter SETUP at cycle 1 → ACCESS + m_pready at cycle 2. That is one extra wait state versus a direct connection.
- Back-to-back:
  - Minimum one IDLE cycle between slave transfers; s_psel drops for one cycle.
  - A master re-requesting immediately competes under the rotated pointer, so there is no starvation. Worst-case wait is NUM_MASTERS-1 transfers.
- Simultaneous requests: resolved only by ptr. Non-granted masters remain in their access-wait with m_pready=0.
- Master drops m_psel while granted (protocol violation):
  - The slave transfer still completes.
  - m_pready is suppressed for the dropped master.
  - ptr advances as normal.
- Writes and reads are treated identically; pwrite only passes through.

Test Plan:
- Reset then idle: preset_n=0 for 2 cycles, no requests → s_psel=0, grant=0, m_pready=0 every cycle.
- Single write:
  - Stimulus: master 0 writes paddr=0x10, pwdata=0xDEADBEEF; slave pready=1 immediately.
  - Required: s_psel at cycle 1, s_penable at cycle 2 with s_paddr=0x10, s_pwdata=0xDEADBEEF. m_pready[0]=1 at cycle 2 only; ptr becomes 1.
- Slave wait states:
  - Stimulus: master 1 reads 0x20; slave holds pready=0 for 3 ACCESS cycles, then returns prdata=0x1234.
  - Required: m_pready[1] rises only in the 4th ACCESS cycle, with m_prdata=0x1234. m_pready[0] stays 0.
- Contention and fairness:
  - Stimulus: both masters request continuously for 4 transfers each, starting with ptr=0.
  - Required: grant sequence 0,1,0,1,… with one IDLE cycle between transfers. No master is granted twice in a row while the other requests.
- Reset mid-transfer:
  - Stimulus: assert preset_n=0 during ACCESS with s_pready=0.
  - Required: the next cycle has s_psel=0, no m_pready pulse, and ptr=0.
- Master abort: master 0 deasserts m_psel during ACCESS → slave transfer finishes, m_pready[0] stays 0, and the arbiter returns to IDLE and then serves master 1.

Source files
------------

// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin sharing of one APB slave port among
// NUM_MASTERS APB masters, with the arbiter driving slave SETUP/ACCESS.
//
// Ports:
//   pclk, preset_n          clock, synchronous active-low reset
//   m_paddr/m_psel/...      packed per-master APB request signals
//   m_pready                per-master ready, only to the granted master
//   m_prdata                slave read data broadcast to all masters
//   s_paddr/s_psel/...      shared APB slave port
//   s_pready, s_prdata      slave response
//   grant                   one-hot owner during SETUP/ACCESS, else 0
module apb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                             pclk,
    input  logic                             preset_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_paddr,
    input  logic [NUM_MASTERS-1:0]            m_psel,
    input  logic [NUM_MASTERS-1:0]            m_penable,
    input  logic [NUM_MASTERS-1:0]            m_pwrite,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_pwdata,
    output logic [NUM_MASTERS-1:0]            m_pready,
    output logic [DATA_WIDTH-1:0]             m_prdata,
    output logic [ADDR_WIDTH-1:0]             s_paddr,
    output logic                              s_psel,
    output logic                              s_penable,
    output logic                              s_pwrite,
    output logic [DATA_WIDTH-1:0]             s_pwdata,
    input  logic                              s_pready,
    input  logic [DATA_WIDTH-1:0]             s_prdata,
    output logic [NUM_MASTERS-1:0]            grant
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]    r_state;
    logic [IW-1:0] r_g;
    logic [IW-1:0] r_ptr;

    logic          w_found;
    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_next_ptr;
    logic          w_active;
    logic          w_access;

    // Scan ptr, ptr+1, ... with wrap. ptr < N and k < N, so a single
    // conditional subtract implements the modulo.
    always_comb begin : pick
        logic [IW:0] w_sum;
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM_MASTERS)) begin
                w_sum = w_sum - (IW+1)'(NUM_MASTERS);
            end
            if (!w_found && m_psel[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IW-1:0];
            end
        end
    end

    assign w_next_ptr = (r_g == IW'(NUM_MASTERS-1)) ? '0 : r_g + IW'(1);

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_g     <= w_pick;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (s_pready) begin
                        r_state <= IDLE;
                        r_ptr   <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_active = (r_state == SETUP) || (r_state == ACCESS);
    assign w_access = (r_state == ACCESS);

    assign s_psel    = w_active;
    assign s_penable = w_access;

    // Masters hold their request stable, so a plain mux on the grant
    // index gives the slave stable signals for the whole transfer.
    assign s_paddr  = w_active ?
                      m_paddr[int'(r_g)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_pwdata = w_active ?
                      m_pwdata[int'(r_g)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign s_pwrite = w_active & m_pwrite[r_g];

    assign m_prdata = s_prdata;

    // Ready is gated by the master's own penable so a master that
    // abandoned its request never sees a stray pready.
    always_comb begin
        m_pready = '0;
        grant    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_pready[i] = w_access && (r_g == IW'(i)) &&
                          s_pready && m_penable[i];
            grant[i]    = w_active && (r_g == IW'(i));
        end
    end

endmodule
